bus_arbiter_wrr: RTL
====================

// Module: bus_arbiter_wrr
// PURPOSE
//  Weighted round-robin bus arbiter; next generation of the fixed bus arbiter.
//  Grants one of NUM_MASTERS requesters at a time. Each master holds the bus for up to
//  WEIGHT[i] consecutive beats while it keeps req high, then yields round-robin.
//  Per-master weights are runtime-programmable and weight 0 masks a master.
//  Sits between the bus masters and the shared slave-side mux; grant drives the mux select.
// PARAMETERS
//  NUM_MASTERS  4  number of requesters, 2..16
//  WEIGHT_W     4  width of each per-master weight/credit field, 1..7
//  AW           $clog2(NUM_MASTERS)  config address width (derived, not overridden)
// PORTS
//  clk          in   1            single clock, rising edge
//  reset        in   1            asynchronous, active-low reset
//  req          in   NUM_MASTERS  request vector, level-sensitive
//  grant        out  NUM_MASTERS  registered grant, one-hot or all-zero
//  grant_id     out  AW           index of current owner; 0 when grant==0
//  grant_valid  out  1            |grant
//  config_wr    in   1            write strobe for a weight register, one cycle
//  config_addr  in   AW           master index being configured
//  config_data  in   8            [WEIGHT_W-1:0]=weight; other bits ignored
// BEHAVIOUR
//  Reset (reset low, async): grant=0, grant_id=0, grant_valid=0, FSM=IDLE, rr_ptr=0,
//   credit=0, all weights=1 (plain round robin). The outputs clear immediately, not at an edge.
//  Eligible(i) = req[i] && weight[i]!=0.
//  Pick: rotating priority over Eligible, starting at rr_ptr and searching upward with wrap.
//  FSM IDLE: if any Eligible, then at the next edge: grant=onehot(pick), credit=weight[pick]-1,
//   rr_ptr=pick+1 (mod NUM_MASTERS), go OWNED. Latency req->grant is 1 edge.
//  FSM OWNED (owner o), evaluated each edge:
//   release if !req[o], or credit==0, or weight[o]==0.
//   Not released: grant holds and credit decrements.
//   Released with another Eligible master: grant switches at this same edge to the new pick.
//    No idle cycle is inserted. Credit reloads for the new owner.
//   Released with o the only Eligible master (credit exhausted): o is re-granted with
//    credit reloaded; grant stays high continuously.
//   Released with none Eligible: grant=0, go IDLE.
//  Beat accounting: every cycle with grant[o]=1 counts as one beat. Weight W gives exactly
//   W consecutive grant cycles before the bus yields, provided others are Eligible.
//  Config: on config_wr, weight[config_addr] <= config_data[WEIGHT_W-1:0] at the edge.
//   A new weight applies to that master's next reload and does not change running credit.
//   Exception: if the written master is the current owner and the new weight is 0, that is
//   a release at the following edge.
//   config_addr >= NUM_MASTERS: the write is ignored.
//  Simultaneous config_wr and arbitration at the same edge: arbitration uses the pre-write
//   weights.
//  req dropping to 0 for all masters mid-burst: grant=0 at the next edge.
//  Reset mid-burst: outputs clear asynchronously. After release, arbitration restarts at rr_ptr=0.
// STRUCTURE
//  Package bus_arbiter_pkg: FSM state enum {IDLE, OWNED}, CFG_WEIGHT_LSB constant,
//   RESET_WEIGHT=1.
//  Sub-module rr_pick #(N): combinational rotating-priority encoder.
//   Inputs: eligible vector, start ptr. Outputs: onehot, index, found.
//  Top holds the weight regfile, credit counter, rr_ptr and FSM.
// TESTING
//  T1 reset: reset=0 with req=1111 -> grant=0000. Release reset -> grant=0001 after 1st edge.
//  T2 equal weights, req=1111 held -> grant 0001,0010,0100,1000,0001..., 1 cycle each, no gaps.
//  T3 write weight[0]=3, req=0011 held -> grant 0001 x3, then 0010 x1, then repeats.
//  T4 write weight[2]=0, req=0100 -> grant stays 0000. Then req=0110 -> only 0010 is granted.
//  T5 weight[1]=4, req=0011 with owner 1: drop req[1] after 2 beats -> grant=0001 at the
//   next edge. Pull reset low mid-burst -> grant=0000 immediately.
//  T6 weight[3]=2, req=1000 held alone -> grant=1000 continuously for 10 cycles with credit
//   reloads. Then raise req[0] -> grant moves to 0001 within 2 cycles.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg : shared types and constants for the weighted RR arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int CFG_WEIGHT_LSB = 0;
  localparam int RESET_WEIGHT   = 1;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational rotating-priority encoder, searches upward from start_i
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] index_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  int cand;

  always_comb begin
    onehot_o = '0;
    index_o  = '0;
    found_o  = 1'b0;
    cand     = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found_o && eligible_i[IW'(cand)]) begin
        found_o              = 1'b1;
        index_o              = IW'(cand);
        onehot_o[IW'(cand)]  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_wrr.sv
// ----------------------------------------------------------------------------
// bus_arbiter_wrr : weighted round-robin bus arbiter with programmable weights
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arbiter_wrr
  import bus_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int WEIGHT_W    = 4,
  localparam int AW          = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [AW-1:0]          grant_id,
  output logic                   grant_valid,
  input  logic                   config_wr,
  input  logic [AW-1:0]          config_addr,
  input  logic [7:0]             config_data
);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [AW-1:0]          grant_id_q;
  logic [WEIGHT_W-1:0]    credit_q;
  logic [AW-1:0]          rr_ptr_q;
  logic [WEIGHT_W-1:0]    weight_q [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic [AW-1:0]          pick_idx;
  logic                   pick_found;
  logic [WEIGHT_W-1:0]    reload_d;
  logic [AW-1:0]          rr_ptr_d;
  logic                   release_own;
  logic                   cfg_addr_ok;
  logic                   unused_cfg_bits;

  generate
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_elig
      assign eligible[i] = req[i] && (weight_q[i] != '0);
    end
  endgenerate

  rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .eligible_i (eligible),
    .start_i    (rr_ptr_q),
    .onehot_o   (pick_onehot),
    .index_o    (pick_idx),
    .found_o    (pick_found)
  );

  // Arbitration reads weight_q before any same-edge config write lands.
  assign reload_d    = weight_q[pick_idx] - WEIGHT_W'(1);
  assign rr_ptr_d    = (pick_idx == AW'(NUM_MASTERS - 1)) ? '0 : pick_idx + AW'(1);
  assign release_own = !req[grant_id_q] || (credit_q == '0) || (weight_q[grant_id_q] == '0);
  assign cfg_addr_ok = ({1'b0, config_addr} < (AW + 1)'(NUM_MASTERS));
  assign unused_cfg_bits = ^config_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MASTERS; i++) weight_q[i] <= WEIGHT_W'(RESET_WEIGHT);
    end else if (config_wr && cfg_addr_ok) begin
      weight_q[config_addr] <= config_data[CFG_WEIGHT_LSB +: WEIGHT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      credit_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q    <= pick_onehot;
            grant_id_q <= pick_idx;
            credit_q   <= reload_d;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= OWNED;
          end
        end
        OWNED: begin
          if (!release_own) begin
            credit_q <= credit_q - WEIGHT_W'(1);
          end else if (pick_found) begin
            // Hand-over happens on this edge; the owner itself wins only if alone.
            grant_q    <= pick_onehot;
            grant_id_q <= pick_idx;
            credit_q   <= reload_d;
            rr_ptr_q   <= rr_ptr_d;
          end else begin
            grant_q    <= '0;
            grant_id_q <= '0;
            credit_q   <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;

endmodule

`default_nettype wire
